// File: rtl/mul_pkg.sv
// Shared types and limits for the sequential shift-add multiplier.
package mul_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MUL_MAX_WIDTH = 32;
endpackage

// File: rtl/mul_seq_step.sv
// One shift-add iteration: conditionally folds the multiplicand into the accumulator.
// MUL_SEQ_SIGNED_EN: the final partial product is subtracted (two's-complement sign bit weight).
module mul_seq_step
  import mul_pkg::*;
#(
  parameter int W2 = 8
) (
  input  logic [W2-1:0] acc_i,
  input  logic [W2-1:0] mcand_i,
  input  logic          mplr0_i,
  input  logic          last_i,
  output logic [W2-1:0] acc_o
);

  always_comb begin
    acc_o = acc_i;
    if (mplr0_i) begin
`ifdef MUL_SEQ_SIGNED_EN
      acc_o = last_i ? (acc_i - mcand_i) : (acc_i + mcand_i);
`else
      acc_o = acc_i + mcand_i;
`endif
    end
  end

`ifndef MUL_SEQ_SIGNED_EN
  logic unused_last;
  assign unused_last = last_i;
`endif

endmodule

// File: rtl/mul_seq.sv
// Iterative multiplier, one partial product per clock; result valid WIDTH edges after accept.
// Optional MUL_SEQ_SIGNED_EN selects two's-complement operands; all outputs come from registers.
module mul_seq
  import mul_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplr_q;
  logic [CNT_W-1:0]   count_q;
  logic [2*WIDTH-1:0] a_ext;
  logic               accept;
  logic               last;

  assign accept = in_valid && (state_q == IDLE);
  assign last   = (count_q == CNT_W'(WIDTH - 1));

`ifdef MUL_SEQ_SIGNED_EN
  assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
`else
  assign a_ext = {{WIDTH{1'b0}}, a};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  mul_seq_step #(
    .W2 (2*WIDTH)
  ) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .mplr0_i (mplr_q[0]),
    .last_i  (last),
    .acc_o   (acc_d)
  );

  // Operands are captured only at accept, so input changes during RUN/DONE are invisible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      count_q <= '0;
    end else if (accept) begin
      acc_q   <= '0;
      mcand_q <= a_ext;
      mplr_q  <= b;
      count_q <= '0;
    end else if (state_q == RUN) begin
      acc_q   <= acc_d;
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign y = acc_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq at WIDTH 2, 4 and 8 (signed expectations under MUL_SEQ_SIGNED_EN).
module tb_mul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic       vld2, rdy2, ovld2, ordy2, busy2;
  logic [1:0] a2, b2;
  logic [3:0] y2;

  logic       vld4, rdy4, ovld4, ordy4, busy4;
  logic [3:0] a4, b4;
  logic [7:0] y4;

  logic        vld8, rdy8, ovld8, ordy8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] y8;

`ifdef MUL_SEQ_SIGNED_EN
  localparam logic [3:0]  E2_33 = 4'd1;
  localparam logic [7:0]  B2B_Y [3] = '{8'hFF, 8'h01, 8'h2A};
  localparam logic [7:0]  A8V [3] = '{8'hFF, 8'h80, 8'h80};
  localparam logic [7:0]  B8V [3] = '{8'hFF, 8'h7F, 8'h80};
  localparam logic [15:0] Y8V [3] = '{16'h0001, 16'hC080, 16'h4000};
`else
  localparam logic [3:0]  E2_33 = 4'd9;
  localparam logic [7:0]  B2B_Y [3] = '{8'd15, 8'd225, 8'd90};
  localparam logic [7:0]  A8V [3] = '{8'd255, 8'd0, 8'd13};
  localparam logic [7:0]  B8V [3] = '{8'd255, 8'd200, 8'd11};
  localparam logic [15:0] Y8V [3] = '{16'd65025, 16'd0, 16'd143};
`endif
  localparam logic [3:0] B2B_A [3] = '{4'd1, 4'd15, 4'd9};
  localparam logic [3:0] B2B_B [3] = '{4'd15, 4'd15, 4'd10};

  mul_seq #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld2), .in_ready(rdy2), .a(a2), .b(b2),
    .out_valid(ovld2), .out_ready(ordy2), .y(y2), .busy(busy2)
  );
  mul_seq #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld4), .in_ready(rdy4), .a(a4), .b(b4),
    .out_valid(ovld4), .out_ready(ordy4), .y(y4), .busy(busy4)
  );
  mul_seq #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld8), .in_ready(rdy8), .a(a8), .b(b8),
    .out_valid(ovld8), .out_ready(ordy8), .y(y8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op2(input string tag, input logic [1:0] av, input logic [1:0] bv, input logic [3:0] exp);
    int n;
    a2 = av; b2 = bv; vld2 = 1'b1; ordy2 = 1'b1;
    tick();
    vld2 = 1'b0;
    check({tag, " in_ready after accept"}, rdy2, 1'b0);
    n = 0;
    while (!ovld2 && n < 40) begin tick(); n++; end
    check({tag, " latency"}, n, 2);
    check({tag, " y"}, y2, exp);
    tick();
    ordy2 = 1'b0;
    check({tag, " back to idle"}, rdy2, 1'b1);
    check({tag, " busy clear"}, busy2, 1'b0);
  endtask

  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic [15:0] exp);
    int n;
    a8 = av; b8 = bv; vld8 = 1'b1; ordy8 = 1'b1;
    tick();
    vld8 = 1'b0;
    check({tag, " busy"}, busy8, 1'b1);
    n = 0;
    while (!ovld8 && n < 40) begin tick(); n++; end
    check({tag, " latency"}, n, 8);
    check({tag, " y"}, y8, exp);
    tick();
    ordy8 = 1'b0;
    check({tag, " back to idle"}, rdy8, 1'b1);
  endtask

  task automatic op4(input string tag, input logic [3:0] av, input logic [3:0] bv,
                     input logic [7:0] exp, input int hold);
    int n;
    a4 = av; b4 = bv; vld4 = 1'b1; ordy4 = 1'b0;
    tick();
    vld4 = 1'b0;
    check({tag, " in_ready after accept"}, rdy4, 1'b0);
    n = 0;
    while (!ovld4 && n < 40) begin tick(); n++; end
    check({tag, " latency"}, n, 4);
    check({tag, " y"}, y4, exp);
    for (int i = 0; i < hold; i++) begin
      vld4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
      tick();
      check({tag, " held out_valid"}, ovld4, 1'b1);
      check({tag, " held y"}, y4, exp);
      check({tag, " held in_ready"}, rdy4, 1'b0);
    end
    vld4 = 1'b0; ordy4 = 1'b1;
    tick();
    ordy4 = 1'b0;
    check({tag, " back to idle"}, rdy4, 1'b1);
    check({tag, " out_valid clear"}, ovld4, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    vld2 = 1'b0; ordy2 = 1'b0; a2 = '0; b2 = '0;
    vld4 = 1'b0; ordy4 = 1'b0; a4 = '0; b4 = '0;
    vld8 = 1'b0; ordy8 = 1'b0; a8 = '0; b8 = '0;
    #2;
    check("reset in_ready", {rdy2, rdy4, rdy8}, 3'b111);
    check("reset out_valid", {ovld2, ovld4, ovld8}, 3'b000);
    check("reset busy", {busy2, busy4, busy8}, 3'b000);
    check("reset y", {y2, y4, y8}, 28'd0);
    #1 rst_n = 1'b1;
    tick();

    op2("w2 3x3", 2'd3, 2'd3, E2_33);

    for (int k = 0; k < 3; k++) op8("w8 op", A8V[k], B8V[k], Y8V[k]);

    op4("w4 5x6 backpressure", 4'd5, 4'd6, 8'd30, 10);

    // Reset during the second RUN cycle must discard the operation.
    a4 = 4'd7; b4 = 4'd7; vld4 = 1'b1;
    tick();
    vld4 = 1'b0;
    tick();
    check("mid-run busy", busy4, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid-run reset in_ready", rdy4, 1'b1);
    check("mid-run reset out_valid", ovld4, 1'b0);
    check("mid-run reset busy", busy4, 1'b0);
    check("mid-run reset y", y4, 8'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("no out_valid after reset", ovld4, 1'b0);
    end
    op4("w4 2x3 after reset", 4'd2, 4'd3, 8'd6, 0);

    // Back-to-back with in_valid and out_ready held high: one result per 6 cycles.
    vld4 = 1'b1; ordy4 = 1'b1; a4 = B2B_A[0]; b4 = B2B_B[0];
    for (int k = 0; k < 3; k++) begin
      tick();
      check("b2b accepted", rdy4, 1'b0);
      if (k < 2) begin
        a4 = B2B_A[k+1]; b4 = B2B_B[k+1];
      end
      repeat (3) tick();
      check("b2b not yet valid", ovld4, 1'b0);
      tick();
      check("b2b out_valid", ovld4, 1'b1);
      check("b2b y", y4, B2B_Y[k]);
      tick();
      check("b2b idle", rdy4, 1'b1);
    end
    vld4 = 1'b0; ordy4 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
